// File: rtl/axi_pkg.sv
// Shared types and helpers for the AXI3 slave memory and its burst address generator.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  // Byte mask covering one wrap window: (len+1) * 2^size bytes, at most 16*128 = 2048.
  function automatic logic [11:0] calc_wrap_mask(input logic [3:0] len, input logic [2:0] size);
    return ((12'(len) + 12'd1) << size) - 12'd1;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address and burst legality for one AXI channel.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        len,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr,
  output logic              illegal
);

  localparam int MAX_SIZE = $clog2(DATA_W/8);

  logic [ADDR_W-1:0] incr, aligned, seq, wmask;

  always_comb begin
    incr    = ADDR_W'(1) << size;
    aligned = addr & ~(incr - ADDR_W'(1));
    seq     = aligned + incr;
    wmask   = ADDR_W'(calc_wrap_mask(len, size));

    next_addr = seq;
    case (burst_e'(burst))
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wmask) | (seq & wmask);
      default:     next_addr = seq;
    endcase

    illegal = (int'(size) > MAX_SIZE);
    if (burst == BURST_WRAP && !(len inside {4'd1, 4'd3, 4'd7, 4'd15})) illegal = 1'b1;
    if (burst == BURST_RSVD) illegal = 1'b1;
  end

endmodule

// File: rtl/axi_slv_mem.sv
// AXI3 slave memory: independent single-outstanding write and read FSMs over a word array.
module axi_slv_mem
  import axi_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 128,
  parameter int                ID_W        = 32,
  parameter int                DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic                clk,
  input  logic                areset,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [3:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                wvalid,
  output logic                wready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  output logic                bvalid,
  input  logic                bready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  input  logic                arvalid,
  output logic                arready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [3:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  output logic                rvalid,
  input  logic                rready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast
);

  localparam int BYTES = DATA_W/8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0] LIMIT = {1'b0, BASE_ADDR} + (ADDR_W+1)'(DEPTH_WORDS*BYTES);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  function automatic logic oob(input logic [ADDR_W-1:0] a);
    return (a < BASE_ADDR) || ({1'b0, a} >= LIMIT);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> OFF_W);
  endfunction

  // ---------------- write channel ----------------
  wr_state_e         w_state_q, w_state_d;
  logic [ID_W-1:0]   aw_id_q, aw_id_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic [3:0]        aw_len_q, aw_len_d, w_cnt_q, w_cnt_d;
  logic [2:0]        aw_size_q, aw_size_d;
  logic [1:0]        aw_burst_q, aw_burst_d;
  logic              w_err_q, w_err_d;
  logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [ID_W-1:0]   bid_q, bid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [ADDR_W-1:0] w_next_addr;
  logic              w_illegal, w_hs, w_oob, w_last_beat, mem_we;

  axi_burst_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wgen (
    .addr(aw_addr_q), .len(aw_len_q), .size(aw_size_q), .burst(aw_burst_q),
    .next_addr(w_next_addr), .illegal(w_illegal)
  );

  always_comb begin
    w_state_d  = w_state_q;
    aw_id_d    = aw_id_q;
    aw_addr_d  = aw_addr_q;
    aw_len_d   = aw_len_q;
    aw_size_d  = aw_size_q;
    aw_burst_d = aw_burst_q;
    w_cnt_d    = w_cnt_q;
    w_err_d    = w_err_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bid_d      = bid_q;
    bresp_d    = bresp_q;
    w_hs        = (w_state_q == W_DATA) && wvalid && wready_q;
    w_oob       = oob(aw_addr_q);
    w_last_beat = (w_cnt_q == aw_len_q);
    mem_we      = w_hs && !w_oob;

    case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (awvalid && awready_q) begin
          aw_id_d    = awid;
          aw_addr_d  = awaddr;
          aw_len_d   = awlen;
          aw_size_d  = awsize;
          aw_burst_d = awburst;
          w_cnt_d    = '0;
          w_err_d    = 1'b0;
          awready_d  = 1'b0;
          wready_d   = 1'b1;
          w_state_d  = W_DATA;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          // Beat count, not wlast, closes the burst; a misplaced wlast only flags the error.
          w_err_d   = w_err_q | w_oob | w_illegal | (wlast != w_last_beat);
          aw_addr_d = w_next_addr;
          w_cnt_d   = w_cnt_q + 4'd1;
          if (w_last_beat) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bid_d     = aw_id_q;
            bresp_d   = w_err_d ? RESP_SLVERR : RESP_OKAY;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (bready && bvalid_q) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      w_state_q  <= W_IDLE;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      w_cnt_q    <= '0;
      w_err_q    <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= '0;
    end else begin
      w_state_q  <= w_state_d;
      aw_id_q    <= aw_id_d;
      aw_addr_q  <= aw_addr_d;
      aw_len_q   <= aw_len_d;
      aw_size_q  <= aw_size_d;
      aw_burst_q <= aw_burst_d;
      w_cnt_q    <= w_cnt_d;
      w_err_q    <= w_err_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bid_q      <= bid_d;
      bresp_q    <= bresp_d;
    end
  end

  // Contents survive reset; a read in the same cycle sees the pre-write word.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < BYTES; b++)
        if (wstrb[b]) mem[word_idx(aw_addr_q)][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  // ---------------- read channel ----------------
  rd_state_e         r_state_q, r_state_d;
  logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
  logic [3:0]        ar_len_q, ar_len_d, r_cnt_q, r_cnt_d;
  logic [2:0]        ar_size_q, ar_size_d;
  logic [1:0]        ar_burst_q, ar_burst_d;
  logic              arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [ADDR_W-1:0] r_src_addr, r_next_addr;
  logic [3:0]        r_src_len;
  logic [2:0]        r_src_size;
  logic [1:0]        r_src_burst;
  logic              r_illegal, r_oob;
  logic [DATA_W-1:0] r_word;

  // In idle the generator looks at the incoming AR fields so beat 0 can be registered on the handshake.
  always_comb begin
    r_src_addr  = (r_state_q == R_IDLE) ? araddr  : ar_addr_q;
    r_src_len   = (r_state_q == R_IDLE) ? arlen   : ar_len_q;
    r_src_size  = (r_state_q == R_IDLE) ? arsize  : ar_size_q;
    r_src_burst = (r_state_q == R_IDLE) ? arburst : ar_burst_q;
  end

  axi_burst_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rgen (
    .addr(r_src_addr), .len(r_src_len), .size(r_src_size), .burst(r_src_burst),
    .next_addr(r_next_addr), .illegal(r_illegal)
  );

  always_comb begin
    r_state_d  = r_state_q;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    ar_size_d  = ar_size_q;
    ar_burst_d = ar_burst_q;
    r_cnt_d    = r_cnt_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rlast_d    = rlast_q;
    rid_d      = rid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    r_oob      = oob(r_src_addr);
    r_word     = r_oob ? '0 : mem[word_idx(r_src_addr)];

    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (arvalid && arready_q) begin
          ar_addr_d  = r_next_addr;
          ar_len_d   = arlen;
          ar_size_d  = arsize;
          ar_burst_d = arburst;
          r_cnt_d    = '0;
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          rid_d      = arid;
          rdata_d    = r_word;
          rresp_d    = (r_oob || r_illegal) ? RESP_SLVERR : RESP_OKAY;
          rlast_d    = (arlen == 4'd0);
          r_state_d  = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid_q && rready) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            ar_addr_d = r_next_addr;
            r_cnt_d   = r_cnt_q + 4'd1;
            rdata_d   = r_word;
            rresp_d   = (r_oob || r_illegal) ? RESP_SLVERR : RESP_OKAY;
            rlast_d   = (r_cnt_q + 4'd1 == ar_len_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      r_state_q  <= R_IDLE;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      r_cnt_q    <= '0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rid_q      <= '0;
      rdata_q    <= '0;
      rresp_q    <= '0;
    end else begin
      r_state_q  <= r_state_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      ar_size_q  <= ar_size_d;
      ar_burst_q <= ar_burst_d;
      r_cnt_q    <= r_cnt_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      rid_q      <= rid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;

endmodule

// File: tb/tb_axi_slv_mem.sv
// Directed bench for axi_slv_mem: bursts, wrap, backpressure, error responses, partial strobes, reset.
module tb_axi_slv_mem;

  logic         clk = 1'b0;
  logic         areset = 1'b0;
  logic         awvalid = 1'b0, awready;
  logic [31:0]  awid = '0, awaddr = '0;
  logic [3:0]   awlen = '0;
  logic [2:0]   awsize = '0;
  logic [1:0]   awburst = '0;
  logic         wvalid = 1'b0, wready, wlast = 1'b0;
  logic [127:0] wdata = '0;
  logic [15:0]  wstrb = '0;
  logic         bvalid, bready = 1'b0;
  logic [31:0]  bid;
  logic [1:0]   bresp;
  logic         arvalid = 1'b0, arready;
  logic [31:0]  arid = '0, araddr = '0;
  logic [3:0]   arlen = '0;
  logic [2:0]   arsize = '0;
  logic [1:0]   arburst = '0;
  logic         rvalid, rready = 1'b0, rlast;
  logic [31:0]  rid;
  logic [127:0] rdata;
  logic [1:0]   rresp;

  axi_slv_mem dut (
    .clk(clk), .areset(areset),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [127:0] wd  [16];
  logic [127:0] rdv [16];
  logic [1:0]   rrs [16];
  logic         rls [16];
  int           nb;
  logic [1:0]   resp;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wr_burst(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input int last_at, input logic [15:0] strb,
                          output logic [1:0] r);
    int t;
    awid = 32'hA000_0000 | addr; awaddr = addr; awlen = len; awsize = size; awburst = burst;
    awvalid = 1'b1;
    t = 0;
    while (!awready && t < 50) begin tick; t++; end
    if (t >= 50) chk("aw_timeout", 0, 1);
    tick;
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wdata = wd[i]; wstrb = strb; wlast = (i == last_at);
      t = 0;
      while (!wready && t < 50) begin tick; t++; end
      if (t >= 50) chk("w_timeout", 0, 1);
      tick;
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    t = 0;
    while (!bvalid && t < 50) begin tick; t++; end
    if (t >= 50) chk("b_timeout", 0, 1);
    r = bresp;
    chk("bid", bid, 32'hA000_0000 | addr);
    tick;
    bready = 1'b0;
  endtask

  task automatic rd_burst(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic bp);
    int t, cyc;
    logic stalled, plast;
    logic [127:0] pdata;
    logic [3:0] pat;
    pat = 4'b1001;
    arid = 32'hB000_0000 | addr; araddr = addr; arlen = len; arsize = size; arburst = burst;
    arvalid = 1'b1;
    t = 0;
    while (!arready && t < 50) begin tick; t++; end
    if (t >= 50) chk("ar_timeout", 0, 1);
    tick;
    arvalid = 1'b0;
    chk("r_latency", rvalid, 1);
    nb = 0; cyc = 0; stalled = 1'b0; pdata = '0; plast = 1'b0;
    while (nb <= int'(len) && cyc < 200) begin
      rready = bp ? pat[cyc % 4] : 1'b1;
      if (stalled) begin
        chk("stall_data", rdata, pdata);
        chk("stall_last", rlast, plast);
      end
      if (rvalid && rready) begin
        rdv[nb] = rdata; rrs[nb] = rresp; rls[nb] = rlast;
        chk("rid", rid, 32'hB000_0000 | addr);
        nb++;
      end
      stalled = rvalid && !rready;
      pdata = rdata; plast = rlast;
      tick;
      cyc++;
    end
    rready = 1'b0;
    chk("r_nbeats", nb, len + 1);
    chk("r_end_rvalid", rvalid, 0);
  endtask

  initial begin
    // Reset state
    areset = 1'b1;
    tick;
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bresp", bresp, 0);
    tick;
    areset = 1'b0;
    tick;
    chk("post_rst_awready", awready, 1);
    chk("post_rst_arready", arready, 1);

    // INCR write then readback
    for (int i = 0; i < 4; i++) wd[i] = 128'h11 * (i + 1);
    wr_burst(32'h0, 4'd3, 3'd4, 2'b01, 3, 16'hFFFF, resp);
    chk("incr_bresp", resp, 2'b00);
    rd_burst(32'h0, 4'd3, 3'd4, 2'b01, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("incr_rdata", rdv[i], 128'h11 * (i + 1));
      chk("incr_rresp", rrs[i], 2'b00);
      chk("incr_rlast", rls[i], i == 3);
    end

    // WRAP read 0x30 -> words 3,0,1,2
    rd_burst(32'h30, 4'd3, 3'd4, 2'b10, 1'b0);
    chk("wrap_b0", rdv[0], 128'h44);
    chk("wrap_b1", rdv[1], 128'h11);
    chk("wrap_b2", rdv[2], 128'h22);
    chk("wrap_b3", rdv[3], 128'h33);
    chk("wrap_rresp", rrs[3], 2'b00);

    // rready backpressure 1,0,0,1
    rd_burst(32'h0, 4'd3, 3'd4, 2'b01, 1'b1);
    for (int i = 0; i < 4; i++) chk("bp_rdata", rdv[i], 128'h11 * (i + 1));
    chk("bp_rlast", rls[3], 1);

    // Early wlast: all 4 beats still land, bresp SLVERR
    for (int i = 0; i < 4; i++) wd[i] = 128'hA1 + 128'(i);
    wr_burst(32'h80, 4'd3, 3'd4, 2'b01, 1, 16'hFFFF, resp);
    chk("early_wlast_bresp", resp, 2'b10);
    rd_burst(32'h80, 4'd3, 3'd4, 2'b01, 1'b0);
    for (int i = 0; i < 4; i++) chk("early_wlast_data", rdv[i], 128'hA1 + 128'(i));

    // Out-of-range single read
    rd_burst(32'h4000, 4'd0, 3'd4, 2'b01, 1'b0);
    chk("oob_rdata", rdv[0], 0);
    chk("oob_rresp", rrs[0], 2'b10);
    chk("oob_rlast", rls[0], 1);

    // Oversized beat is an error for the burst
    wd[0] = '0;
    wr_burst(32'hC0, 4'd0, 3'd5, 2'b01, 0, 16'hFFFF, resp);
    chk("bigsize_bresp", resp, 2'b10);

    // Partial strobe over zeros
    wd[0] = '0;
    wr_burst(32'h40, 4'd0, 3'd4, 2'b01, 0, 16'hFFFF, resp);
    wd[0] = '1;
    wr_burst(32'h40, 4'd0, 3'd4, 2'b01, 0, 16'h000F, resp);
    chk("strb_bresp", resp, 2'b00);
    rd_burst(32'h40, 4'd0, 3'd4, 2'b01, 1'b0);
    chk("strb_rdata", rdv[0], 128'hFFFF_FFFF);

    // Reset during beat 2 of a read
    araddr = 32'h0; arlen = 4'd3; arsize = 3'd4; arburst = 2'b01; arid = 32'h77;
    arvalid = 1'b1;
    tick;
    arvalid = 1'b0;
    rready = 1'b1;
    tick;
    tick;
    chk("mid_beat2", rdata, 128'h33);
    rready = 1'b0;
    areset = 1'b1;
    tick;
    chk("mid_rst_rvalid", rvalid, 0);
    areset = 1'b0;
    tick;
    chk("mid_rst_arready", arready, 1);
    chk("mid_rst_rvalid2", rvalid, 0);
    rd_burst(32'h10, 4'd0, 3'd4, 2'b01, 1'b0);
    chk("retain_data", rdv[0], 128'h22);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
